norm_seq: RTL and testbench

Sequencing controller for one `norm` lane (4-bit FIFO plus running-sum divider). It accepts a vector of `len` elements over a valid/ready stream and clears the lane before each vector. It then loads every element into the lane, issues one divide per element once the lane reports ready, and streams the normalised results out with valid/ready backpressure. It sits between the upstream element source and the `norm` instance it owns.

---
 rtl/norm_seq.sv | 107 ++++++++++
 tb/tb_norm_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/norm_seq.sv
// norm_seq: sequencer that clears a norm lane, loads a vector, issues one divide per element and streams results out.
module norm_seq #(
  parameter int bw    = 4,
  parameter int DEPTH = 8,
  parameter int LW    = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [LW-1:0]   i_len,
  input  logic            i_in_valid,
  input  logic [bw-1:0]   i_in_data,
  output logic            o_in_ready,
  output logic            o_out_valid,
  output logic [2*bw-1:0] o_out_data,
  input  logic            i_out_ready,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic            o_n_reset,
  output logic            o_n_wr,
  output logic            o_n_div,
  output logic [bw-1:0]   o_n_in,
  input  logic            i_n_full,
  input  logic            i_n_ready,
  input  logic [2*bw-1:0] i_n_out
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, ISSUE, WAIT, HOLD, DONE} state_t;
  localparam logic [LW-1:0] L_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] L_ONE   = LW'(1);
  state_t            r_state, w_next;
  logic [LW-1:0]     r_remaining, r_total;
  logic [2*bw-1:0]   r_acc, r_out_data, w_sum;
  logic              r_zero, r_first, r_out_valid, r_err;
  logic              w_xfer, w_last, w_hs, w_zero_sum;
  assign w_xfer     = r_state == LOAD && i_in_valid && !i_n_full;
  assign w_last     = w_xfer && r_remaining == L_ONE;
  assign w_sum      = r_acc + (2*bw)'(i_in_data);
  assign w_zero_sum = w_last && w_sum == '0;
  assign w_hs       = r_state == HOLD && r_out_valid && i_out_ready;
  always_ff @(posedge i_clk)
    if (i_reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = !i_start ? IDLE : i_len == '0 ? DONE : i_len <= L_DEPTH ? CLEAR : IDLE;
      CLEAR: w_next = LOAD;
      LOAD:  w_next = !w_last ? LOAD : w_sum != '0 ? ISSUE : HOLD;
      ISSUE: w_next = i_n_ready ? WAIT : ISSUE;
      WAIT:  w_next = !r_first && i_n_ready ? HOLD : WAIT;
      HOLD:  w_next = !w_hs ? HOLD : r_total == L_ONE ? DONE : r_zero ? HOLD : ISSUE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    o_busy      = r_state != IDLE;
    o_done      = r_state == DONE;
    o_n_reset   = r_state == CLEAR && !i_reset;
    o_in_ready  = r_state == LOAD && !i_n_full;
    o_n_wr      = w_xfer;
    o_n_in      = w_xfer ? i_in_data : '0;
    o_n_div     = r_state == ISSUE && i_n_ready;
    o_out_valid = r_out_valid;
    o_out_data  = r_out_data;
    o_err       = r_err;
  end
  // r_first marks the WAIT cycle right after the divide, where the lane's ready is still stale
  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_remaining <= '0;
      r_total     <= '0;
      r_acc       <= '0;
      r_zero      <= 1'b0;
      r_first     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err   <= (r_state == IDLE && i_start && i_len > L_DEPTH) || w_zero_sum;
      r_first <= r_state == ISSUE;
      if (r_state == IDLE && i_start) begin
        r_remaining <= i_len;
        r_total     <= i_len;
        r_acc       <= '0;
        r_zero      <= 1'b0;
      end
      if (w_xfer) begin
        r_acc       <= w_sum;
        r_remaining <= r_remaining - L_ONE;
      end
      if (w_zero_sum) begin
        r_zero      <= 1'b1;
        r_out_valid <= 1'b1;
        r_out_data  <= '0;
      end
      if (r_state == WAIT && !r_first && i_n_ready) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_n_out;
      end
      if (w_hs) begin
        r_total     <= r_total - L_ONE;
        r_out_valid <= r_zero && r_total != L_ONE;
      end
    end
endmodule

// File: tb/tb_norm_seq.sv
// tb_norm_seq: directed table-driven bench for norm_seq with a behavioural norm lane
// (FIFO + running sum, divide result {elem,8'b0}/sum ready 3 cycles after the divide cycle).
module tb_norm_seq;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] len = '0, in_data = '0, n_in;
  logic       in_ready, out_valid, busy, done, err, n_reset, n_wr, n_div, n_full, n_ready;
  logic [7:0] out_data, n_out;
  int n_checks = 0, n_errors = 0, div_cnt = 0;

  norm_seq #(.bw(4), .DEPTH(8), .LW(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_len(len),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_n_reset(n_reset), .o_n_wr(n_wr), .o_n_div(n_div), .o_n_in(n_in),
    .i_n_full(n_full), .i_n_ready(n_ready), .i_n_out(n_out));

  always #5 clk = ~clk;

  logic [3:0] lm [8];
  logic [2:0] wp, rp, dcnt;
  logic [3:0] lcnt;
  logic [7:0] lsum, lpend;
  assign n_full  = lcnt == 4'd8;
  assign n_ready = dcnt == 3'd0;

  function automatic logic [7:0] quot(input logic [3:0] e, input logic [7:0] s);
    logic [11:0] num, den;
    num = {e, 8'h00};
    den = {4'h0, s};
    return s == 8'd0 ? 8'd0 : num / den;
  endfunction

  always @(posedge clk) begin
    if (reset || n_reset) begin
      wp <= '0; rp <= '0; lcnt <= '0; lsum <= '0;
      if (reset) begin dcnt <= '0; n_out <= '0; lpend <= '0; end
    end else begin
      if (n_wr) begin lm[wp] <= n_in; wp <= wp + 3'd1; lsum <= lsum + {4'h0, n_in}; end
      lcnt <= lcnt + {3'b0, n_wr} - {3'b0, n_div};
      if (n_div) begin rp <= rp + 3'd1; lpend <= quot(lm[rp], lsum); dcnt <= 3'd3; end
      else if (dcnt != 3'd0) begin dcnt <= dcnt - 3'd1; if (dcnt == 3'd1) n_out <= lpend; end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (!reset && n_div) begin
    div_cnt++;
    check("div_needs_ready", {31'b0, n_ready}, 1);
    check("div_while_result_held", {31'b0, out_valid}, 0);
  end

  typedef struct {
    int         len;
    logic [3:0] e [8];
    int         stall;
    int         n_err;
    int         n_res;
    logic [7:0] r [8];
    int         n_div;
  } vec_t;
  vec_t tbl [6];

  task automatic check_reset_vals();
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data", {24'b0, out_data}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_n_wr", {31'b0, n_wr}, 0);
    check("rst_n_div", {31'b0, n_div}, 0);
    check("rst_n_in", {28'b0, n_in}, 0);
    check("rst_n_reset", {31'b0, n_reset}, 0);
  endtask

  task automatic run_vector(input int idx, input bit abort);
    vec_t t;
    int k = 0, r = 0, stall = 0, errs = 0, cyc = 0;
    bit fire = 1'b0, held = 1'b0, fin = 1'b0;
    logic [7:0] hd = '0;
    t = tbl[idx];
    div_cnt = 0;
    start = 1'b1;
    len = 4'(t.len);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d_busy_t1", idx), {31'b0, busy}, 1);
    check($sformatf("v%0d_n_reset_t1", idx), {31'b0, n_reset}, 1);
    while (!fin && cyc < 400) begin
      if (fire) k++;
      in_valid = k < t.len;
      in_data  = k < 8 ? t.e[k] : 4'h0;
      fire = in_valid && in_ready;
      if (held) begin
        check($sformatf("v%0d_hold_valid", idx), {31'b0, out_valid}, 1);
        check($sformatf("v%0d_hold_data", idx), {24'b0, out_data}, {24'b0, hd});
      end
      if (err) errs++;
      if (abort && n_div) begin
        in_valid = 1'b0;
        return;
      end
      if (out_valid) begin
        if (stall < t.stall) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          check($sformatf("v%0d_result%0d", idx, r), {24'b0, out_data}, {24'b0, r < 8 ? t.r[r] : 8'hxx});
          r++;
          stall = 0;
        end
      end else out_ready = t.stall == 0;
      held = out_valid && !out_ready;
      hd   = out_data;
      if (done) begin
        fin = 1'b1;
        check($sformatf("v%0d_result_count", idx), r, t.n_res);
        check($sformatf("v%0d_err_pulses", idx), errs, t.n_err);
        check($sformatf("v%0d_div_count", idx), div_cnt, t.n_div);
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (!fin) check($sformatf("v%0d_done_timeout", idx), 0, 1);
    check($sformatf("v%0d_busy_after_done", idx), {31'b0, busy}, 0);
    check($sformatf("v%0d_done_pulse_width", idx), {31'b0, done}, 0);
  endtask

  initial begin
    tbl[0] = '{len: 4, e: '{4, 4, 4, 4, 0, 0, 0, 0}, stall: 0, n_err: 0, n_res: 4,
               r: '{8'h40, 8'h40, 8'h40, 8'h40, 0, 0, 0, 0}, n_div: 4};
    tbl[1] = '{len: 3, e: '{1, 2, 5, 0, 0, 0, 0, 0}, stall: 0, n_err: 0, n_res: 3,
               r: '{8'h20, 8'h40, 8'hA0, 0, 0, 0, 0, 0}, n_div: 3};
    tbl[2] = '{len: 3, e: '{1, 2, 5, 0, 0, 0, 0, 0}, stall: 5, n_err: 0, n_res: 3,
               r: '{8'h20, 8'h40, 8'hA0, 0, 0, 0, 0, 0}, n_div: 3};
    tbl[3] = '{len: 2, e: '{0, 0, 0, 0, 0, 0, 0, 0}, stall: 0, n_err: 1, n_res: 2,
               r: '{8'h00, 8'h00, 0, 0, 0, 0, 0, 0}, n_div: 0};
    tbl[4] = '{len: 8, e: '{1, 2, 3, 4, 5, 6, 7, 8}, stall: 0, n_err: 0, n_res: 8,
               r: '{8'h07, 8'h0E, 8'h15, 8'h1C, 8'h23, 8'h2A, 8'h31, 8'h38}, n_div: 8};
    tbl[5] = '{len: 1, e: '{8, 0, 0, 0, 0, 0, 0, 0}, stall: 0, n_err: 0, n_res: 1,
               r: '{8'h00, 0, 0, 0, 0, 0, 0, 0}, n_div: 1};
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_vector(i, 1'b0);
    start = 1'b1;
    len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("len0_done", {31'b0, done}, 1);
    check("len0_busy", {31'b0, busy}, 1);
    check("len0_no_err", {31'b0, err}, 0);
    check("len0_no_n_reset", {31'b0, n_reset}, 0);
    check("len0_no_out", {31'b0, out_valid}, 0);
    @(negedge clk);
    check("len0_done_low", {31'b0, done}, 0);
    check("len0_idle", {31'b0, busy}, 0);
    start = 1'b1;
    len = 4'd9;
    @(negedge clk);
    start = 1'b0;
    check("len9_err", {31'b0, err}, 1);
    check("len9_idle", {31'b0, busy}, 0);
    check("len9_no_n_reset", {31'b0, n_reset}, 0);
    @(negedge clk);
    check("len9_err_pulse", {31'b0, err}, 0);
    check("len9_still_idle", {31'b0, busy}, 0);
    run_vector(0, 1'b1);
    @(negedge clk);
    check("abort_in_wait", {31'b0, busy}, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    run_vector(5, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
